// File: rtl/arith_pkg.sv
// Shared arithmetic-library types: serial subtractor FSM states and counter sizing.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } sub_state_t;

  // Bit-counter width for a WIDTH-bit serial operation (never narrower than 1)
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// 1-bit full subtractor cell: a - b - borrow_in.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic f_diff,
  output logic f_borrow
);

  assign f_diff   = A ^ B ^ Bin;
  assign f_borrow = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one bit per clock through a single cell.
// Result is latched into dedicated output registers so diff/bout stay put while shifting.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = cnt_w(WIDTH);

  sub_state_t       state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr, b_sr, d_sr, diff_q;
  logic             br, bout_q;
  logic             cell_d, cell_br;
  logic             last;

  full_subtractor u_fs (
    .A       (a_sr[0]),
    .B       (b_sr[0]),
    .Bin     (br),
    .f_diff  (cell_d),
    .f_borrow(cell_br)
  );

  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = SHIFT;
      SHIFT:   if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      a_sr   <= '0;
      b_sr   <= '0;
      d_sr   <= '0;
      br     <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sr <= a;
          b_sr <= b;
          br   <= bin;
          cnt  <= '0;
        end
        SHIFT: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          d_sr <= {cell_d, d_sr[WIDTH-1:1]};
          br   <= cell_br;
          cnt  <= cnt + CW'(1);
          // Final bit: publish the completed word and borrow together
          if (last) begin
            diff_q <= {cell_d, d_sr[WIDTH-1:1]};
            bout_q <= cell_br;
          end
        end
        default: ;
      endcase
    end
  end

  // in_ready is masked by rst so it reads 0 for the whole reset window
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed + random checks of serial_subtractor at WIDTH=4 and WIDTH=8 against plain arithmetic.
module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic [7:0] a, b;
  logic       bin;
  logic       iv4, ir4, ov4, or4, bo4;
  logic       iv8, ir8, ov8, or8, bo8;
  logic [3:0] d4;
  logic [7:0] d8;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4),
    .a(a[3:0]), .b(b[3:0]), .bin(bin),
    .out_valid(ov4), .out_ready(or4), .diff(d4), .bout(bo4)
  );

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
    .a(a), .b(b), .bin(bin),
    .out_valid(ov8), .out_ready(or8), .diff(d8), .bout(bo8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic g_ir(input int sel);
    return (sel != 0) ? ir8 : ir4;
  endfunction
  function automatic logic g_ov(input int sel);
    return (sel != 0) ? ov8 : ov4;
  endfunction
  function automatic logic [7:0] g_d(input int sel);
    return (sel != 0) ? d8 : {4'b0, d4};
  endfunction
  function automatic logic g_b(input int sel);
    return (sel != 0) ? bo8 : bo4;
  endfunction

  task automatic set_valid(input int sel, input logic v);
    if (sel != 0) iv8 = v; else iv4 = v;
  endtask
  task automatic set_ready(input int sel, input logic v);
    if (sel != 0) or8 = v; else or4 = v;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full request/response transaction with optional response stall.
  // Called and returns at a negedge; block is IDLE on return.
  task automatic op(input int sel, input logic [7:0] ta, input logic [7:0] tbv,
                    input logic tbin, input int stall);
    int         n;
    int         e;
    logic [7:0] mask, ed, hd;
    logic       eb, hb;
    mask = (sel != 0) ? 8'hFF : 8'h0F;
    e    = int'(ta & mask) - int'(tbv & mask) - int'(tbin);
    ed   = 8'(e) & mask;
    eb   = (e < 0);
    a = ta; b = tbv; bin = tbin;
    set_ready(sel, 1'b0);
    set_valid(sel, 1'b1);
    n = 0;
    while (!g_ir(sel) && n < 50) begin @(negedge clk); n++; end
    chk("accept_wait", 32'(n < 50), 32'd1);
    @(negedge clk);
    set_valid(sel, 1'b0);
    // Scramble operand inputs to prove they were captured
    a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
    n = 0;
    while (!g_ov(sel) && n < 100) begin @(negedge clk); n++; end
    chk("latency", 32'(n), (sel != 0) ? 32'd8 : 32'd4);
    chk("diff", 32'(g_d(sel)), 32'(ed));
    chk("bout", 32'(g_b(sel)), 32'(eb));
    hd = g_d(sel);
    hb = g_b(sel);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("hold_ov", 32'(g_ov(sel)), 32'd1);
      chk("hold_diff", 32'(g_d(sel)), 32'(hd));
      chk("hold_bout", 32'(g_b(sel)), 32'(hb));
      chk("hold_in_ready", 32'(g_ir(sel)), 32'd0);
    end
    set_ready(sel, 1'b1);
    @(negedge clk);
    set_ready(sel, 1'b0);
    chk("release_ov", 32'(g_ov(sel)), 32'd0);
    chk("release_in_ready", 32'(g_ir(sel)), 32'd1);
  endtask

  initial begin
    int n;
    int hi;
    rst = 1'b1;
    a = '0; b = '0; bin = 1'b0;
    iv4 = 1'b0; or4 = 1'b0; iv8 = 1'b0; or8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready4", 32'(ir4), 32'd0);
    chk("rst_out_valid4", 32'(ov4), 32'd0);
    chk("rst_diff4", 32'(d4), 32'd0);
    chk("rst_bout4", 32'(bo4), 32'd0);
    chk("rst_in_ready8", 32'(ir8), 32'd0);
    chk("rst_diff8", 32'(d8), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready4", 32'(ir4), 32'd1);
    chk("post_rst_in_ready8", 32'(ir8), 32'd1);

    // Directed WIDTH=4 cases
    op(0, 8'd9, 8'd3, 1'b0, 0);
    op(0, 8'd3, 8'd9, 1'b0, 0);
    op(0, 8'd0, 8'd0, 1'b1, 0);
    op(0, 8'hF, 8'hF, 1'b0, 0);
    op(0, 8'd3, 8'd9, 1'b1, 5);   // backpressure
    op(0, 8'd12, 8'd5, 1'b0, 0);  // accepted right after stalled result

    // Busy ignore: a request pulse during SHIFT must not disturb the result
    a = 8'd9; b = 8'd3; bin = 1'b0; or4 = 1'b1; iv4 = 1'b1;
    @(negedge clk);
    iv4 = 1'b0;
    @(negedge clk);
    a = 8'd1; b = 8'd1; iv4 = 1'b1;
    @(negedge clk);
    iv4 = 1'b0;
    n = 0;
    while (!ov4 && n < 50) begin @(negedge clk); n++; end
    chk("busy_ov", 32'(ov4), 32'd1);
    chk("busy_diff", 32'(d4), 32'd6);
    chk("busy_bout", 32'(bo4), 32'd0);
    hi = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ov4) hi++;
    end
    chk("busy_single_episode", 32'(hi), 32'd0);
    or4 = 1'b0;

    // Reset in the second SHIFT cycle discards the operation
    a = 8'd9; b = 8'd3; bin = 1'b0; or4 = 1'b1; iv4 = 1'b1;
    @(negedge clk);
    iv4 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ov", 32'(ov4), 32'd0);
    chk("midrst_diff", 32'(d4), 32'd0);
    chk("midrst_bout", 32'(bo4), 32'd0);
    chk("midrst_in_ready", 32'(ir4), 32'd0);
    rst = 1'b0;
    or4 = 1'b0;
    hi = 0;
    for (int i = 0; i < 6; i++) begin
      if (ov4) hi++;
      @(negedge clk);
    end
    chk("midrst_no_ov", 32'(hi), 32'd0);
    chk("midrst_in_ready_after", 32'(ir4), 32'd1);
    op(0, 8'd5, 8'd2, 1'b0, 0);

    // Random at both widths with random response stalls
    for (int i = 0; i < 1000; i++)
      op(0, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), 1'($urandom),
         int'($urandom_range(0, 3)));
    for (int i = 0; i < 1000; i++)
      op(1, 8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
